rst_seq_ctrl: RTL

- Reset sequencer and arbiter for the SoC reset tree.
- Collects reset requests from JTAG/debug (ndmreset), watchdog and software (CSR write), and picks one cause by priority.
- Drives staged, registered reset releases: peripherals first, then core.
- Sits between the top-level reset synchronizer and the core/peripheral reset inputs; records the last reset cause for firmware.

---
 rtl/rst_pkg.sv | 31 +++
 rtl/rst_seq_ctrl.sv | 120 ++++++++++++
 2 files changed

// File: rtl/rst_pkg.sv
// Reset sequencer package.
// Holds the sequencer state and reset-cause encodings, plus the priority
// encoder that picks a single cause from the three request sources.
package rst_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    ASSERT     = 2'd1,
    REL_PERIPH = 2'd2
  } rst_state_e;

  typedef enum logic [1:0] {
    CAUSE_POR  = 2'd0,
    CAUSE_JTAG = 2'd1,
    CAUSE_WDG  = 2'd2,
    CAUSE_SW   = 2'd3
  } rst_cause_e;

  // JTAG > WDG > SW; POR only when nothing is requesting.
  function automatic rst_cause_e prio_cause(input logic jtag, input logic wdg, input logic sw);
    if (jtag) begin
      return CAUSE_JTAG;
    end else if (wdg) begin
      return CAUSE_WDG;
    end else if (sw) begin
      return CAUSE_SW;
    end
    return CAUSE_POR;
  endfunction

endpackage

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer and arbiter for the SoC reset tree.
// Collects JTAG (level), watchdog (pulse) and software (pulse) reset requests,
// records the winning cause and releases the peripheral reset, then the core
// reset, after programmable hold and gap intervals.
// Ports:
//   clk, rst_n       system clock, async active-low reset (sync deassert upstream)
//   jtag_rst_req_i   debug ndmreset level; reset held while high
//   wdg_rst_req_i    watchdog single-cycle pulse
//   sw_rst_req_i     CSR software-reset single-cycle pulse
//   periph_rst_n_o   registered active-low peripheral reset
//   core_rst_n_o     registered active-low core reset
//   rst_busy_o       high whenever the sequence is not in RUN
//   rst_cause_o      last reset cause (0 POR, 1 JTAG, 2 WDG, 3 SW)
module rst_seq_ctrl
  import rst_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 8,
  parameter int unsigned GAP_CYCLES  = 4,
  parameter int unsigned CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       jtag_rst_req_i,
  input  logic       wdg_rst_req_i,
  input  logic       sw_rst_req_i,
  output logic       periph_rst_n_o,
  output logic       core_rst_n_o,
  output logic       rst_busy_o,
  output logic [1:0] rst_cause_o
);

  if (CNT_W < 1 || CNT_W > 31 ||
      HOLD_CYCLES < 1 || HOLD_CYCLES > (2 ** CNT_W) - 1 ||
      GAP_CYCLES < 1 || GAP_CYCLES > (2 ** CNT_W) - 1) begin : g_bad_params
    $error("rst_seq_ctrl: HOLD_CYCLES/GAP_CYCLES must be 1..2^CNT_W-1");
  end

  localparam logic [CNT_W-1:0] HoldLast = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GapLast  = CNT_W'(GAP_CYCLES - 1);

  rst_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  rst_cause_e       cause_q, cause_d;
  logic             periph_q, periph_d;
  logic             core_q, core_d;
  logic             busy_q, busy_d;
  logic             req_any;
  rst_cause_e       winner;

  always_comb begin
    req_any = jtag_rst_req_i | wdg_rst_req_i | sw_rst_req_i;
    winner  = prio_cause(jtag_rst_req_i, wdg_rst_req_i, sw_rst_req_i);
    state_d = state_q;
    cnt_d   = cnt_q;
    cause_d = cause_q;

    // A sampled request beats any timer expiry in every state.
    if (req_any) begin
      state_d = ASSERT;
      cnt_d   = '0;
      cause_d = winner;
    end else begin
      case (state_q)
        RUN: begin
          cnt_d = '0;
        end
        ASSERT: begin
          if (cnt_q == HoldLast) begin
            state_d = REL_PERIPH;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        REL_PERIPH: begin
          if (cnt_q == GapLast) begin
            state_d = RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = ASSERT;
          cnt_d   = '0;
        end
      endcase
    end

    // Outputs are decoded from the next state so they are plain flops with
    // the same timing as the state register.
    periph_d = (state_d != ASSERT);
    core_d   = (state_d == RUN);
    busy_d   = (state_d != RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ASSERT;
      cnt_q    <= '0;
      cause_q  <= CAUSE_POR;
      periph_q <= 1'b0;
      core_q   <= 1'b0;
      busy_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cause_q  <= cause_d;
      periph_q <= periph_d;
      core_q   <= core_d;
      busy_q   <= busy_d;
    end
  end

  assign periph_rst_n_o = periph_q;
  assign core_rst_n_o   = core_q;
  assign rst_busy_o     = busy_q;
  assign rst_cause_o    = cause_q;

endmodule
